// File: rtl/test_phy_bist_if.sv
// MAC user-side transmit/receive bundle shared by the link BIST and the MAC.
// master = BIST (drives tx, observes rx); slave = MAC/loopback side.
interface test_phy_bist_if #(
  parameter int unsigned W = 32
);
  logic [W-1:0] mac_tx_data;
  logic         mac_tx_valid;
  logic         mac_tx_sof;
  logic         mac_tx_eof;
  logic [W-1:0] mac_rx_data;
  logic         mac_rx_valid;
  logic         mac_rx_sof;
  logic         mac_rx_eof;
  logic         mac_rx_fr_good;
  logic         mac_rx_fr_err;

  modport master (
    output mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof,
    input  mac_rx_data, mac_rx_valid, mac_rx_sof, mac_rx_eof,
    input  mac_rx_fr_good, mac_rx_fr_err
  );

  modport slave (
    input  mac_tx_data, mac_tx_valid, mac_tx_sof, mac_tx_eof,
    output mac_rx_data, mac_rx_valid, mac_rx_sof, mac_rx_eof,
    output mac_rx_fr_good, mac_rx_fr_err
  );
endinterface

// File: rtl/test_phy_bist.sv
// Link BIST: sends numbered fixed-length frames on MAC tx and checks the
// looped-back stream on MAC rx, raising a sticky err on any framing/data fault.
module test_phy_bist #(
  parameter int unsigned TEST_DATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN       = 64,
  parameter int unsigned IFG             = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  test_phy_bist_if.master            mac,
  output logic                       err,
  output logic [TEST_DATA_WIDTH-1:0] test_data
);
  localparam int unsigned W     = TEST_DATA_WIDTH;
  localparam int unsigned IDX_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned GAP_W = $clog2(IFG + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(IFG - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     tx_seq_q, tx_seq_d;
  logic [IDX_W-1:0] tx_idx_q, tx_idx_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [W-1:0]     tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_sof_q, tx_sof_d;
  logic             tx_eof_q, tx_eof_d;

  logic [W-1:0]     rx_seq_q, rx_seq_d;
  logic [W-1:0]     rx_exp_q, rx_exp_d;
  logic [IDX_W-1:0] rx_idx_q, rx_idx_d;
  logic             in_frame_q, in_frame_d;
  logic             err_q, err_d;
  logic [W-1:0]     test_data_q, test_data_d;
  logic [W-1:0]     exp_word;
  logic [IDX_W-1:0] idx_next;
  logic             rx_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tx_seq_q    <= '0;
      tx_idx_q    <= '0;
      gap_cnt_q   <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_sof_q    <= 1'b0;
      tx_eof_q    <= 1'b0;
      rx_seq_q    <= '0;
      rx_exp_q    <= '0;
      rx_idx_q    <= '0;
      in_frame_q  <= 1'b0;
      err_q       <= 1'b0;
      test_data_q <= '0;
    end else begin
      state_q     <= state_d;
      tx_seq_q    <= tx_seq_d;
      tx_idx_q    <= tx_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_sof_q    <= tx_sof_d;
      tx_eof_q    <= tx_eof_d;
      rx_seq_q    <= rx_seq_d;
      rx_exp_q    <= rx_exp_d;
      rx_idx_q    <= rx_idx_d;
      in_frame_q  <= in_frame_d;
      err_q       <= err_d;
      test_data_q <= test_data_d;
    end
  end

  // Generator: the word for index k is registered out one cycle after SEND sees k.
  always_comb begin
    state_d    = state_q;
    tx_seq_d   = tx_seq_q;
    tx_idx_d   = tx_idx_q;
    gap_cnt_d  = gap_cnt_q;
    tx_data_d  = '0;
    tx_valid_d = 1'b0;
    tx_sof_d   = 1'b0;
    tx_eof_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SEND;
          tx_idx_d = '0;
        end
      end
      ST_SEND: begin
        tx_valid_d = 1'b1;
        tx_data_d  = tx_seq_q + W'(tx_idx_q);
        tx_sof_d   = (tx_idx_q == '0);
        tx_eof_d   = (tx_idx_q == LAST_IDX);
        if (tx_idx_q == LAST_IDX) begin
          tx_seq_d  = tx_seq_q + W'(1);
          tx_idx_d  = '0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          tx_idx_d = tx_idx_q + IDX_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d = start ? ST_SEND : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Checker: tracks sof/eof framing only, so any loopback latency or gaps are fine.
  always_comb begin
    rx_seq_d    = rx_seq_q;
    rx_exp_d    = rx_exp_q;
    rx_idx_d    = rx_idx_q;
    in_frame_d  = in_frame_q;
    test_data_d = test_data_q;
    rx_fault    = 1'b0;
    exp_word    = rx_exp_q + W'(1);
    idx_next    = rx_idx_q + IDX_W'(1);
    if (mac.mac_rx_valid) begin
      test_data_d = mac.mac_rx_data;
      if (mac.mac_rx_sof) begin
        if (in_frame_q || (mac.mac_rx_data != rx_seq_q)) rx_fault = 1'b1;
        rx_exp_d   = rx_seq_q;
        rx_idx_d   = '0;
        in_frame_d = 1'b1;
        // a one-word frame can never be legal since frames are at least two words
        if (mac.mac_rx_eof) begin
          rx_fault   = 1'b1;
          rx_seq_d   = rx_seq_q + W'(1);
          in_frame_d = 1'b0;
        end
      end else if (!in_frame_q) begin
        rx_fault = 1'b1;
      end else begin
        if (mac.mac_rx_data != exp_word) rx_fault = 1'b1;
        rx_exp_d = exp_word;
        rx_idx_d = idx_next;
        if (mac.mac_rx_eof) begin
          if ((idx_next != LAST_IDX) || !mac.mac_rx_fr_good || mac.mac_rx_fr_err) rx_fault = 1'b1;
          rx_seq_d   = rx_seq_q + W'(1);
          in_frame_d = 1'b0;
        end else if (idx_next == LAST_IDX) begin
          rx_fault = 1'b1;
        end
      end
    end
    err_d = err_q | rx_fault;
  end

  assign mac.mac_tx_data  = tx_data_q;
  assign mac.mac_tx_valid = tx_valid_q;
  assign mac.mac_tx_sof   = tx_sof_q;
  assign mac.mac_tx_eof   = tx_eof_q;
  assign err              = err_q;
  assign test_data        = test_data_q;
endmodule

// File: tb/tb_test_phy_bist.sv
// Bench for test_phy_bist: queue-based loopback with fault injection and a
// frame-level reference model of the tx stream and of the sticky error flag.
module tb_test_phy_bist;
  localparam int unsigned W   = 32;
  localparam int unsigned FL  = 64;
  localparam int unsigned GAP = 8;

  localparam int F_NONE      = 0;
  localparam int F_FLIP      = 1;
  localparam int F_DROP_EOF  = 2;
  localparam int F_FR_ERR    = 3;
  localparam int F_NO_GOOD   = 4;
  localparam int F_DROP_SOF  = 5;
  localparam int F_EXTRA_SOF = 6;
  localparam int F_EARLY_EOF = 7;

  typedef struct {
    logic [W-1:0] data;
    logic         sof;
    logic         eof;
    logic         good;
    logic         ferr;
    logic         bad;
  } rx_word_t;

  typedef struct {
    int           kind;
    int           frame;
    int           word;
    int           nfr;
    bit           gaps;
    logic         exp_err;
    logic [W-1:0] exp_td;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         err;
  logic [W-1:0] test_data;

  always #5 clk = ~clk;

  test_phy_bist_if #(.W(W)) mac ();

  test_phy_bist #(.TEST_DATA_WIDTH(W), .FRAME_LEN(FL), .IFG(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mac       (mac),
    .err       (err),
    .test_data (test_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Fault injection controls and reference model state.
  int           f_kind = F_NONE;
  int           f_frame = 0;
  int           f_word = 0;
  bit           gap_mode = 1'b0;
  rx_word_t     q[$];
  int           tx_k;
  int           idle_cnt;
  int           sof_cnt;
  int           eof_cnt;
  bit           start_low;
  bit           have_prev;
  logic [W-1:0] tx_seq;
  logic         exp_err;
  logic [W-1:0] exp_td;
  logic         rx_bad_cur;

  // Model + loopback, evaluated on the falling edge between DUT clock edges.
  always @(negedge clk) begin
    rx_word_t e;
    if (!rst_n) begin
      check_word("reset_tx_data", mac.mac_tx_data, '0);
      check_word("reset_flags", W'({mac.mac_tx_valid, mac.mac_tx_sof, mac.mac_tx_eof, err}), '0);
      check_word("reset_test_data", test_data, '0);
      tx_k = -1; idle_cnt = 0; sof_cnt = 0; eof_cnt = 0;
      start_low = 1'b0; have_prev = 1'b0; tx_seq = '0;
      exp_err = 1'b0; exp_td = '0; rx_bad_cur = 1'b0;
      q.delete();
      mac.mac_rx_data = '0; mac.mac_rx_valid = 1'b0; mac.mac_rx_sof = 1'b0;
      mac.mac_rx_eof = 1'b0; mac.mac_rx_fr_good = 1'b0; mac.mac_rx_fr_err = 1'b0;
    end else begin
      // Effect of the rx word presented at the clock edge just past.
      if (mac.mac_rx_valid) exp_td = mac.mac_rx_data;
      if (rx_bad_cur) exp_err = 1'b1;
      check_bit("err", err, exp_err);
      check_word("test_data", test_data, exp_td);

      if (mac.mac_tx_valid) begin
        if (tx_k < 0) begin
          if (have_prev) begin
            if (!start_low) check_word("ifg", W'(idle_cnt), W'(GAP));
            else check_bit("ifg_min", idle_cnt >= int'(GAP), 1'b1);
          end
          tx_k = 0;
          sof_cnt++;
        end
        check_word("tx_data", mac.mac_tx_data, tx_seq + W'(tx_k));
        check_bit("tx_sof", mac.mac_tx_sof, tx_k == 0);
        check_bit("tx_eof", mac.mac_tx_eof, tx_k == int'(FL) - 1);
        e.data = mac.mac_tx_data; e.sof = mac.mac_tx_sof; e.eof = mac.mac_tx_eof;
        e.good = mac.mac_tx_eof; e.ferr = 1'b0; e.bad = 1'b0;
        if (f_kind != F_NONE && sof_cnt - 1 == f_frame && tx_k == f_word) begin
          e.bad = 1'b1;
          case (f_kind)
            F_FLIP:      e.data = e.data ^ W'(1);
            F_DROP_EOF:  e.eof = 1'b0;
            F_FR_ERR:    e.ferr = 1'b1;
            F_NO_GOOD:   e.good = 1'b0;
            F_DROP_SOF:  e.sof = 1'b0;
            F_EXTRA_SOF: e.sof = 1'b1;
            F_EARLY_EOF: begin e.eof = 1'b1; e.good = 1'b1; end
            default:     e.bad = 1'b0;
          endcase
        end
        q.push_back(e);
        if (tx_k == int'(FL) - 1) begin
          tx_seq = tx_seq + W'(1); tx_k = -1; idle_cnt = 0;
          eof_cnt++; start_low = 1'b0; have_prev = 1'b1;
        end else begin
          tx_k++;
        end
      end else begin
        check_bit("tx_valid_in_frame", mac.mac_tx_valid, tx_k >= 0);
        check_bit("tx_idle_flags", mac.mac_tx_sof | mac.mac_tx_eof, 1'b0);
        if (tx_k < 0) begin
          idle_cnt++;
          if (!start) start_low = 1'b1;
        end
      end

      // Loopback: one-cycle registered path, or random holes when gap_mode is set.
      if (q.size() > 0 && (!gap_mode || $urandom_range(0, 99) < 80)) begin
        e = q.pop_front();
        mac.mac_rx_data = e.data; mac.mac_rx_valid = 1'b1; mac.mac_rx_sof = e.sof;
        mac.mac_rx_eof = e.eof; mac.mac_rx_fr_good = e.good; mac.mac_rx_fr_err = e.ferr;
        rx_bad_cur = e.bad;
      end else begin
        mac.mac_rx_data = W'($urandom); mac.mac_rx_valid = 1'b0; mac.mac_rx_sof = 1'b0;
        mac.mac_rx_eof = 1'b0; mac.mac_rx_fr_good = 1'b0; mac.mac_rx_fr_err = 1'b0;
        rx_bad_cur = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reset with start held high, then check first sof arrives one cycle after start is seen.
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("sof_latency_idle", mac.mac_tx_valid, 1'b0);
    @(negedge clk);
    check_bit("first_sof", mac.mac_tx_valid & mac.mac_tx_sof, 1'b1);
    check_word("first_sof_data", mac.mac_tx_data, '0);
    #1;
  endtask

  // Keep start high until frame nfr-1 has begun, then drop it and drain.
  task automatic run_frames(input int nfr);
    start = 1'b1;
    for (int c = 0; c < (nfr + 1) * int'(FL + GAP) + 10 && sof_cnt < nfr; c++) tick();
    check_word("frames_started", W'(sof_cnt), W'(nfr));
    start = 1'b0;
    for (int c = 0; c < 4000 && !(q.size() == 0 && tx_k < 0 && idle_cnt > int'(GAP) + 2
                                  && !mac.mac_rx_valid); c++) tick();
    check_bit("drained", q.size() == 0 && tx_k < 0, 1'b1);
    repeat (GAP + 4) tick();
    check_word("frames_sent", W'(eof_cnt), W'(nfr));
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{F_NONE,      0,  0, 10, 1'b0, 1'b0, W'(72)};
    vecs[1] = '{F_FLIP,      2,  5,  4, 1'b0, 1'b1, W'(66)};
    vecs[2] = '{F_DROP_EOF,  1, 63,  4, 1'b0, 1'b1, W'(66)};
    vecs[3] = '{F_FR_ERR,    0, 63,  4, 1'b0, 1'b1, W'(66)};
    vecs[4] = '{F_NO_GOOD,   3, 63,  4, 1'b0, 1'b1, W'(66)};
    vecs[5] = '{F_DROP_SOF,  1,  0,  4, 1'b0, 1'b1, W'(66)};
    vecs[6] = '{F_EXTRA_SOF, 1, 10,  4, 1'b0, 1'b1, W'(66)};
    vecs[7] = '{F_EARLY_EOF, 2, 62,  4, 1'b0, 1'b1, W'(66)};
    vecs[8] = '{F_NONE,      0,  0,  6, 1'b1, 1'b0, W'(68)};

    for (int i = 0; i < 9; i++) begin
      f_kind = vecs[i].kind; f_frame = vecs[i].frame; f_word = vecs[i].word;
      gap_mode = vecs[i].gaps;
      do_reset();
      run_frames(vecs[i].nfr);
      check_bit($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      check_word($sformatf("vec%0d_test_data", i), test_data, vecs[i].exp_td);
    end

    // Stop mid-frame at a random word, then restart: sequence must continue.
    f_kind = F_NONE; gap_mode = 1'b0;
    do_reset();
    begin
      int stop_at;
      stop_at = int'($urandom_range(5, 50));
      for (int c = 0; c < 200 && tx_k < stop_at; c++) tick();
      start = 1'b0;
      repeat (FL + GAP + 20) tick();
      check_word("stop_one_frame", W'(eof_cnt), W'(1));
      check_bit("stop_idle", mac.mac_tx_valid, 1'b0);
      start = 1'b1;
      for (int c = 0; c < 20 && !mac.mac_tx_valid; c++) @(negedge clk);
      check_bit("restart_sof", mac.mac_tx_sof, 1'b1);
      check_word("restart_seq", mac.mac_tx_data, W'(1));
      #1;
      run_frames(3);
      check_bit("restart_err", err, 1'b0);
      check_word("restart_test_data", test_data, W'(2 + FL - 1));
    end

    // Asynchronous reset mid-frame with err already set.
    f_kind = F_FLIP; f_frame = 0; f_word = 3;
    do_reset();
    for (int c = 0; c < 400 && !(sof_cnt == 2 && tx_k > 20); c++) tick();
    check_bit("pre_reset_err", err, 1'b1);
    check_bit("pre_reset_valid", mac.mac_tx_valid, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_word("async_reset_flags", W'({mac.mac_tx_valid, mac.mac_tx_sof, mac.mac_tx_eof, err}), '0);
    check_word("async_reset_data", mac.mac_tx_data, '0);
    check_word("async_reset_test_data", test_data, '0);
    f_kind = F_NONE;
    do_reset();
    run_frames(2);
    check_bit("post_reset_err", err, 1'b0);
    check_word("post_reset_test_data", test_data, W'(1 + FL - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
